register_file_controller: RTL and testbench
===========================================

REGISTER_FILE_CONTROLLER -- requirements
Module: register_file_controller

Interface
REQ-001 Parameter: COUNT_W, default 4, width of the increment-count field.
REQ-002 Clock  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 CmdValid  in  1  command request.
REQ-005 CmdReady  out  1  controller accepts a command; a command is accepted on a rising edge with CmdValid&&CmdReady.
REQ-006 CmdOp  in  2  opcode: 00 CLEAR, 01 LOAD32, 10 INCN, 11 MOVE.
REQ-007 CmdDst  in  3  destination: 000-011 R1-R4, 100-111 S1-S4.
REQ-008 CmdSrc  in  3  MOVE source, same encoding as CmdDst.
REQ-009 CmdData  in  32  LOAD32 value.
REQ-010 CmdCount  in  COUNT_W  INCN repeat count; 0 means 2^COUNT_W.
REQ-011 RfOutA  in  32  register-file OutA, registered inside the register file (one-edge latency from OutASel).
REQ-012 RfI  out  32  register-file data input.
REQ-013 RfFunSel  out  3  register-file function select.
REQ-014 RfRegSel  out  4  R1..R4 enables, R1 = bit 3.
REQ-015 RfScrSel  out  4  S1..S4 enables, S1 = bit 3.
REQ-016 RfOutASel  out  3  register-file A read select.
REQ-017 Busy  out  1  high in every non-IDLE state.
REQ-018 Done  out  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, LOAD, INC, MOVE_RD, MOVE_WR and DONE.
REQ-020 CmdDst, CmdSrc, CmdData and CmdCount SHALL be latched at acceptance; input changes after acceptance SHALL have no effect.
REQ-021 The destination mask SHALL be one-hot: 0xx selects RfRegSel bit (3-dst[1:0]); 1xx selects RfScrSel bit (3-dst[1:0]); the other mask SHALL be 0.
REQ-022 In IDLE and DONE: RfRegSel=0, RfScrSel=0, RfFunSel=010, RfI=0; no register-file write SHALL occur.
REQ-023 CLEAR SHALL last 1 cycle: RfFunSel=011 with the destination mask; then DONE.
REQ-024 LOAD SHALL last 4 cycles with byte index k=0..3.
  - k=0: RfFunSel=100, RfI={24'b0, Data[31:24]}.
  - k=1..3: RfFunSel=110, RfI={24'b0, next lower byte}.
  - After 4 cycles the destination SHALL hold Data; then DONE.
REQ-025 INC SHALL assert RfFunSel=001 with the destination mask for exactly N cycles (N = CmdCount, or 2^COUNT_W when 0); then DONE.
REQ-026 MOVE_RD SHALL last 1 cycle: RfOutASel=Src, masks 0.
REQ-027 MOVE_WR SHALL last 1 cycle: RfOutASel=Src held, RfFunSel=010, RfI=RfOutA (combinational pass-through), destination mask; then DONE.
REQ-028 MOVE with Src==Dst SHALL execute normally and leave the value unchanged.
REQ-029 DONE SHALL last 1 cycle with Done=1 and CmdReady=0; then IDLE.
REQ-030 CmdReady SHALL be 1 only in IDLE with Reset low; back-to-back commands SHALL be separated by at least the DONE cycle.
REQ-031 Outside MOVE, RfOutASel SHALL hold its last value.
REQ-032 Throughput: CLEAR 3 cycles, LOAD32 6, INCN N+2, MOVE 4, each counted from the acceptance edge to the next CmdReady.

Reset
REQ-033 While Reset is high, the controller SHALL immediately be in IDLE, with all of the following:
  - RfRegSel=0, RfScrSel=0, RfFunSel=010, RfI=0, RfOutASel=000;
  - Busy=0, Done=0, CmdReady=0;
  - all counters and latched command fields cleared.
REQ-034 Reset during an operation SHALL abort it with no further writes; the register-file contents SHALL be left as partially written.
REQ-035 CmdValid SHALL be ignored while Reset is high; CmdReady SHALL rise in the first cycle after Reset falls.

Verification
REQ-036 Scenario LOAD32 R3, Data=0xDEADBEEF -> 4 write cycles, RfRegSel=0010, RfI=0xDE,0xAD,0xBE,0xEF; a behavioural register-file model reads R3=0xDEADBEEF; Done pulses once.
REQ-037 Scenario LOAD32 S2=0x12345678, then MOVE Src=S2 Dst=R1 -> MOVE_WR cycle shows RfRegSel=1000, RfScrSel=0000, RfI=0x12345678; model R1=0x12345678.
REQ-038 Scenario INCN R4 with CmdCount=0 after CLEAR R4 -> exactly 16 cycles at RfFunSel=001; R4=0x00000010; Busy high for 17 cycles.
REQ-039 Scenario CmdValid held high across two queued commands (CLEAR S4, then INCN S4 count 3) -> second command accepted only after the DONE cycle; S4=3.
REQ-040 Scenario Reset asserted in LOAD k=1 mid-cycle -> masks drop to 0 asynchronously; destination low byte keeps only the first byte; CmdReady=1 in the first cycle after release.
REQ-041 Scenario every op with each of the 8 Dst codes -> exactly one mask bit set in each write cycle, matching REQ-021.

Source files
------------

// File: rtl/register_file_controller.sv
// Sequences CLEAR / LOAD32 / INCN / MOVE commands into register-file control strobes.
// Latency: CLEAR 3, LOAD32 6, INCN N+2, MOVE 4 cycles from acceptance to the next ready.
// Backpressure: o_cmd_ready is high only in IDLE with reset low; one command in flight.
module register_file_controller #(
    parameter int COUNT_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [2:0]         i_cmd_dst,
    input  logic [2:0]         i_cmd_src,
    input  logic [31:0]        i_cmd_data,
    input  logic [COUNT_W-1:0] i_cmd_count,
    input  logic [31:0]        i_rf_out_a,
    output logic [31:0]        o_rf_i,
    output logic [2:0]         o_rf_fun_sel,
    output logic [3:0]         o_rf_reg_sel,
    output logic [3:0]         o_rf_scr_sel,
    output logic [2:0]         o_rf_out_a_sel,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_INC,
        S_MOVE_RD,
        S_MOVE_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_LOAD32 = 2'b01;
    localparam logic [1:0] OP_INCN   = 2'b10;
    localparam logic [1:0] OP_MOVE   = 2'b11;

    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LOAD  = 3'b010;
    localparam logic [2:0] FS_CLR   = 3'b011;
    localparam logic [2:0] FS_LDLO  = 3'b100;
    localparam logic [2:0] FS_SHLD  = 3'b110;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_dst;
    logic [31:0]          r_data;
    logic [COUNT_W-1:0]   r_cnt;
    logic [1:0]           r_byte;
    logic [2:0]           r_out_a_sel;

    logic                 w_accept;
    logic                 w_wr;
    logic [3:0]           w_dst_mask;

    assign o_cmd_ready    = (r_state == S_IDLE) && !i_rst;
    assign w_accept       = i_cmd_valid && o_cmd_ready;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_rf_out_a_sel = r_out_a_sel;

    // One-hot enable within the selected bank; R1/S1 sit at bit 3.
    assign w_dst_mask     = 4'b1000 >> r_dst[1:0];
    assign o_rf_reg_sel   = (w_wr && !r_dst[2]) ? w_dst_mask : 4'b0000;
    assign o_rf_scr_sel   = (w_wr &&  r_dst[2]) ? w_dst_mask : 4'b0000;

    // State register; reset forces IDLE immediately so all write enables drop at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command fields are captured at acceptance so later input changes cannot disturb the op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dst       <= 3'b000;
            r_data      <= 32'd0;
            r_cnt       <= '0;
            r_byte      <= 2'd0;
            r_out_a_sel <= 3'b000;
        end else begin
            if (w_accept) begin
                r_dst  <= i_cmd_dst;
                r_data <= i_cmd_data;
                r_cnt  <= i_cmd_count;
                r_byte <= 2'd0;
                // Read select only moves for MOVE and otherwise keeps its last value.
                if (i_cmd_op == OP_MOVE) begin
                    r_out_a_sel <= i_cmd_src;
                end
            end
            if (r_state == S_LOAD) begin
                r_byte <= r_byte + 2'd1;
            end
            // Count of 0 wraps through all ones, giving 2^COUNT_W increments.
            if (r_state == S_INC) begin
                r_cnt <= r_cnt - COUNT_W'(1);
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_cmd_op)
                        OP_CLEAR:  w_next = S_CLEAR;
                        OP_LOAD32: w_next = S_LOAD;
                        OP_INCN:   w_next = S_INC;
                        default:   w_next = S_MOVE_RD;
                    endcase
                end
            end
            S_CLEAR:   w_next = S_DONE;
            S_LOAD:    w_next = (r_byte == 2'd3) ? S_DONE : S_LOAD;
            S_INC:     w_next = (r_cnt == COUNT_W'(1)) ? S_DONE : S_INC;
            S_MOVE_RD: w_next = S_MOVE_WR;
            S_MOVE_WR: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Register-file strobes per state; IDLE/DONE/MOVE_RD fall through to the no-write defaults.
    always_comb begin
        w_wr         = 1'b0;
        o_rf_fun_sel = FS_LOAD;
        o_rf_i       = 32'd0;
        case (r_state)
            S_CLEAR: begin
                o_rf_fun_sel = FS_CLR;
                w_wr         = 1'b1;
            end
            S_LOAD: begin
                // First byte clears the upper bits, later bytes shift in MSB-first.
                o_rf_fun_sel = (r_byte == 2'd0) ? FS_LDLO : FS_SHLD;
                w_wr         = 1'b1;
                case (r_byte)
                    2'd0:    o_rf_i = {24'd0, r_data[31:24]};
                    2'd1:    o_rf_i = {24'd0, r_data[23:16]};
                    2'd2:    o_rf_i = {24'd0, r_data[15:8]};
                    default: o_rf_i = {24'd0, r_data[7:0]};
                endcase
            end
            S_INC: begin
                o_rf_fun_sel = FS_INC;
                w_wr         = 1'b1;
            end
            S_MOVE_WR: begin
                // OutA was registered by the file during MOVE_RD; pass it straight through.
                o_rf_i = i_rf_out_a;
                w_wr   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_register_file_controller.sv
// Self-checking bench for register_file_controller with a behavioural register file.
// Expected register contents come from a command-level model; strobes from the command rules.
// Commands are issued one at a time except the held-valid back-to-back scenario.
module tb_register_file_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op = 2'b00;
    logic [2:0]  i_cmd_dst = 3'b000;
    logic [2:0]  i_cmd_src = 3'b000;
    logic [31:0] i_cmd_data = 32'd0;
    logic [3:0]  i_cmd_count = 4'd0;
    logic [31:0] i_rf_out_a;
    logic [31:0] o_rf_i;
    logic [2:0]  o_rf_fun_sel;
    logic [3:0]  o_rf_reg_sel;
    logic [3:0]  o_rf_scr_sel;
    logic [2:0]  o_rf_out_a_sel;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    register_file_controller #(.COUNT_W(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_op       (i_cmd_op),
        .i_cmd_dst      (i_cmd_dst),
        .i_cmd_src      (i_cmd_src),
        .i_cmd_data     (i_cmd_data),
        .i_cmd_count    (i_cmd_count),
        .i_rf_out_a     (i_rf_out_a),
        .o_rf_i         (o_rf_i),
        .o_rf_fun_sel   (o_rf_fun_sel),
        .o_rf_reg_sel   (o_rf_reg_sel),
        .o_rf_scr_sel   (o_rf_scr_sel),
        .o_rf_out_a_sel (o_rf_out_a_sel),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    // Behavioural register file: index 0..3 = R1..R4, 4..7 = S1..S4; OutA registered.
    logic [31:0] m_rf [8] = '{default: 32'd0};
    logic [31:0] m_out_a = 32'd0;
    assign i_rf_out_a = m_out_a;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if ((i < 4) ? o_rf_reg_sel[3-i] : o_rf_scr_sel[7-i]) begin
                case (o_rf_fun_sel)
                    3'b001:  m_rf[i] <= m_rf[i] + 32'd1;
                    3'b010:  m_rf[i] <= o_rf_i;
                    3'b011:  m_rf[i] <= 32'd0;
                    3'b100:  m_rf[i] <= {24'd0, o_rf_i[7:0]};
                    3'b110:  m_rf[i] <= {m_rf[i][23:0], o_rf_i[7:0]};
                    default: ;
                endcase
            end
        end
        m_out_a <= m_rf[o_rf_out_a_sel];
    end

    // Command-level reference of what each register should hold.
    logic [31:0] exp_rf [8] = '{default: 32'd0};

    function automatic void ref_apply(input int op, input int dst, input int src,
                                      input logic [31:0] data, input int cnt);
        case (op)
            0:       exp_rf[dst] = 32'd0;
            1:       exp_rf[dst] = data;
            2:       exp_rf[dst] = exp_rf[dst] + ((cnt == 0) ? 32'd16 : 32'(cnt));
            default: exp_rf[dst] = exp_rf[src];
        endcase
    endfunction

    // Per-cycle trace of one command, from the first cycle after acceptance to DONE.
    logic [2:0]  t_fun  [64];
    logic [3:0]  t_reg  [64];
    logic [3:0]  t_scr  [64];
    logic [31:0] t_rfi  [64];
    logic [2:0]  t_sel  [64];
    logic        t_busy [64];
    logic        t_done [64];
    logic        t_rdy  [64];
    int          t_len;
    logic        post_rdy;

    task automatic send(input int op, input int dst, input int src,
                        input logic [31:0] data, input int cnt);
        int w = 0;
        @(negedge clk);
        while (!o_cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_cmd_ready) begin
            n_checks++;
            $display("FAIL send_ready: CmdReady=%b after %0d cycles, required 1", o_cmd_ready, w);
        end
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'(op);
        i_cmd_dst   = 3'(dst);
        i_cmd_src   = 3'(src);
        i_cmd_data  = data;
        i_cmd_count = 4'(cnt);
        @(posedge clk);
        #1;
        // Scramble the command inputs to show they are not used after acceptance.
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'($urandom_range(0, 3));
        i_cmd_dst   = 3'($urandom_range(0, 7));
        i_cmd_src   = 3'($urandom_range(0, 7));
        i_cmd_data  = $urandom;
        i_cmd_count = 4'($urandom_range(0, 15));
    endtask

    task automatic capture();
        t_len = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            t_fun[t_len]  = o_rf_fun_sel;
            t_reg[t_len]  = o_rf_reg_sel;
            t_scr[t_len]  = o_rf_scr_sel;
            t_rfi[t_len]  = o_rf_i;
            t_sel[t_len]  = o_rf_out_a_sel;
            t_busy[t_len] = o_busy;
            t_done[t_len] = o_done;
            t_rdy[t_len]  = o_cmd_ready;
            t_len++;
            if (o_done) break;
        end
        @(negedge clk);
        post_rdy = o_cmd_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_op = 2'b01;
        i_cmd_dst = 3'd2;
        repeat (3) @(negedge clk);
        n_checks++; if (o_cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b, expected 0", o_cmd_ready); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", o_busy); else n_pass++;
        n_checks++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b, expected 0", o_done); else n_pass++;
        n_checks++; if (o_rf_fun_sel !== 3'b010) $display("FAIL rst_fun: got %b, expected 010", o_rf_fun_sel); else n_pass++;
        n_checks++; if ({o_rf_reg_sel, o_rf_scr_sel} !== 8'h00) $display("FAIL rst_masks: got %b_%b, expected 0000_0000", o_rf_reg_sel, o_rf_scr_sel); else n_pass++;
        n_checks++; if (o_rf_i !== 32'd0) $display("FAIL rst_rfi: got %h, expected 0", o_rf_i); else n_pass++;
        n_checks++; if (o_rf_out_a_sel !== 3'd0) $display("FAIL rst_sel: got %0d, expected 0", o_rf_out_a_sel); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (o_cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b, expected 1", o_cmd_ready); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_release_busy: got %b, expected 0", o_busy); else n_pass++;
    endtask

    task automatic test_load();
        logic [31:0] d = 32'hDEADBEEF;
        int n_done = 0;
        int n_busy = 0;
        send(1, 2, 0, d, 0);
        capture();
        ref_apply(1, 2, 0, d, 0);
        n_checks++; if (t_len !== 5) $display("FAIL load_len: got %0d cycles, expected 5", t_len); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (t_fun[k] !== ((k == 0) ? 3'b100 : 3'b110)) $display("FAIL load_fun%0d: got %b", k, t_fun[k]); else n_pass++;
            n_checks++; if ({t_reg[k], t_scr[k]} !== 8'b0010_0000) $display("FAIL load_mask%0d: got %b_%b, expected 0010_0000", k, t_reg[k], t_scr[k]); else n_pass++;
            n_checks++; if (t_rfi[k] !== ((d >> (8 * (3 - k))) & 32'hFF)) $display("FAIL load_rfi%0d: got %h, expected %h", k, t_rfi[k], (d >> (8 * (3 - k))) & 32'hFF); else n_pass++;
        end
        for (int k = 0; k < t_len; k++) begin
            if (t_done[k]) n_done++;
            if (t_busy[k]) n_busy++;
        end
        n_checks++; if (n_done !== 1) $display("FAIL load_done_count: got %0d, expected 1", n_done); else n_pass++;
        n_checks++; if (n_busy !== 5) $display("FAIL load_busy_count: got %0d, expected 5", n_busy); else n_pass++;
        n_checks++; if (t_rdy[t_len-1] !== 1'b0) $display("FAIL load_done_ready: got %b, expected 0", t_rdy[t_len-1]); else n_pass++;
        n_checks++; if (post_rdy !== 1'b1) $display("FAIL load_post_ready: got %b, expected 1", post_rdy); else n_pass++;
        n_checks++; if (m_rf[2] !== exp_rf[2]) $display("FAIL load_r3: got %h, expected %h", m_rf[2], exp_rf[2]); else n_pass++;
    endtask

    task automatic test_move();
        send(1, 5, 0, 32'h12345678, 0);
        capture();
        ref_apply(1, 5, 0, 32'h12345678, 0);
        n_checks++; if (m_rf[5] !== exp_rf[5]) $display("FAIL move_s2_load: got %h, expected %h", m_rf[5], exp_rf[5]); else n_pass++;
        send(3, 0, 5, $urandom, 0);
        capture();
        ref_apply(3, 0, 5, 32'd0, 0);
        n_checks++; if (t_len !== 3) $display("FAIL move_len: got %0d, expected 3", t_len); else n_pass++;
        n_checks++; if ({t_reg[0], t_scr[0], t_sel[0]} !== {8'h00, 3'd5}) $display("FAIL move_rd: masks %b_%b sel %0d, expected 0000_0000 sel 5", t_reg[0], t_scr[0], t_sel[0]); else n_pass++;
        n_checks++; if (t_fun[1] !== 3'b010) $display("FAIL move_wr_fun: got %b, expected 010", t_fun[1]); else n_pass++;
        n_checks++; if ({t_reg[1], t_scr[1]} !== 8'b1000_0000) $display("FAIL move_wr_mask: got %b_%b, expected 1000_0000", t_reg[1], t_scr[1]); else n_pass++;
        n_checks++; if (t_rfi[1] !== 32'h12345678) $display("FAIL move_wr_rfi: got %h, expected 12345678", t_rfi[1]); else n_pass++;
        n_checks++; if (t_sel[1] !== 3'd5) $display("FAIL move_wr_sel: got %0d, expected 5", t_sel[1]); else n_pass++;
        n_checks++; if (m_rf[0] !== exp_rf[0]) $display("FAIL move_r1: got %h, expected %h", m_rf[0], exp_rf[0]); else n_pass++;
        send(3, 5, 5, $urandom, 0);
        capture();
        ref_apply(3, 5, 5, 32'd0, 0);
        n_checks++; if (m_rf[5] !== exp_rf[5]) $display("FAIL move_self: got %h, expected %h", m_rf[5], exp_rf[5]); else n_pass++;
    endtask

    task automatic test_inc16();
        int n_inc = 0;
        int n_busy = 0;
        send(0, 3, 0, $urandom, 0);
        capture();
        ref_apply(0, 3, 0, 32'd0, 0);
        n_checks++; if ({t_fun[0], t_reg[0], t_scr[0]} !== {3'b011, 8'b0001_0000}) $display("FAIL clear_r4: fun %b masks %b_%b, expected 011 0001_0000", t_fun[0], t_reg[0], t_scr[0]); else n_pass++;
        n_checks++; if (t_len !== 2) $display("FAIL clear_len: got %0d, expected 2", t_len); else n_pass++;
        send(2, 3, 0, $urandom, 0);
        capture();
        ref_apply(2, 3, 0, 32'd0, 0);
        for (int k = 0; k < t_len; k++) begin
            if (t_fun[k] === 3'b001 && t_reg[k] === 4'b0001) n_inc++;
            if (t_busy[k]) n_busy++;
        end
        n_checks++; if (n_inc !== 16) $display("FAIL inc16_cycles: got %0d, expected 16", n_inc); else n_pass++;
        n_checks++; if (n_busy !== 17) $display("FAIL inc16_busy: got %0d, expected 17", n_busy); else n_pass++;
        n_checks++; if (m_rf[3] !== exp_rf[3]) $display("FAIL inc16_r4: got %h, expected %h", m_rf[3], exp_rf[3]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c = 0;
        int w = 0;
        logic seen_done = 1'b0;
        logic [2:0] f0 = 3'b000;
        logic [3:0] s0 = 4'b0000;
        @(negedge clk);
        while (!o_cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b00;
        i_cmd_dst   = 3'd7;
        @(posedge clk);
        #1;
        ref_apply(0, 7, 0, 32'd0, 0);
        i_cmd_op    = 2'b10;
        i_cmd_count = 4'd3;
        while (c < 10) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                f0 = o_rf_fun_sel;
                s0 = o_rf_scr_sel;
            end
            if (o_done) seen_done = 1'b1;
            if (o_cmd_ready) break;
        end
        n_checks++; if (c !== 3) $display("FAIL b2b_gap: ready after %0d cycles, expected 3", c); else n_pass++;
        n_checks++; if (seen_done !== 1'b1) $display("FAIL b2b_done_first: got %b, expected 1", seen_done); else n_pass++;
        n_checks++; if ({f0, s0} !== {3'b011, 4'b0001}) $display("FAIL b2b_first_op: fun %b scr %b, expected 011 0001", f0, s0); else n_pass++;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        ref_apply(2, 7, 0, 32'd0, 3);
        capture();
        n_checks++; if (t_len !== 4) $display("FAIL b2b_inc_len: got %0d, expected 4", t_len); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if ({t_fun[k], t_scr[k]} !== {3'b001, 4'b0001}) $display("FAIL b2b_inc%0d: fun %b scr %b, expected 001 0001", k, t_fun[k], t_scr[k]); else n_pass++;
        end
        n_checks++; if (m_rf[7] !== exp_rf[7]) $display("FAIL b2b_s4: got %h, expected %h", m_rf[7], exp_rf[7]); else n_pass++;
    endtask

    task automatic test_all_dst();
        for (int d = 0; d < 8; d++) begin
            for (int op = 0; op < 4; op++) begin
                logic [31:0] data = $urandom;
                int src = $urandom_range(0, 7);
                int cnt = $urandom_range(0, 15);
                int exp_len;
                logic [3:0] e_reg = (d < 4) ? (4'b1000 >> d) : 4'b0000;
                logic [3:0] e_scr = (d >= 4) ? (4'b1000 >> (d - 4)) : 4'b0000;
                logic [2:0] e_fun;
                send(op, d, src, data, cnt);
                capture();
                ref_apply(op, d, src, data, cnt);
                case (op)
                    0:       exp_len = 2;
                    1:       exp_len = 5;
                    2:       exp_len = ((cnt == 0) ? 16 : cnt) + 1;
                    default: exp_len = 3;
                endcase
                n_checks++; if (t_len !== exp_len) $display("FAIL dst%0d_op%0d_len: got %0d, expected %0d", d, op, t_len, exp_len); else n_pass++;
                for (int k = 0; k < t_len - 1; k++) begin
                    if (op == 3 && k == 0) begin
                        n_checks++; if ({t_reg[k], t_scr[k], t_sel[k]} !== {8'h00, 3'(src)}) $display("FAIL dst%0d_move_rd: masks %b_%b sel %0d, expected 0000_0000 sel %0d", d, t_reg[k], t_scr[k], t_sel[k], src); else n_pass++;
                    end else begin
                        case (op)
                            0:       e_fun = 3'b011;
                            1:       e_fun = (k == 0) ? 3'b100 : 3'b110;
                            2:       e_fun = 3'b001;
                            default: e_fun = 3'b010;
                        endcase
                        n_checks++; if ({t_fun[k], t_reg[k], t_scr[k]} !== {e_fun, e_reg, e_scr}) $display("FAIL dst%0d_op%0d_wr%0d: fun %b masks %b_%b, expected %b %b_%b", d, op, k, t_fun[k], t_reg[k], t_scr[k], e_fun, e_reg, e_scr); else n_pass++;
                    end
                end
                n_checks++; if ({t_done[t_len-1], t_reg[t_len-1], t_scr[t_len-1]} !== 9'b1_0000_0000) $display("FAIL dst%0d_op%0d_done: done %b masks %b_%b", d, op, t_done[t_len-1], t_reg[t_len-1], t_scr[t_len-1]); else n_pass++;
                n_checks++; if (m_rf[d] !== exp_rf[d]) $display("FAIL dst%0d_op%0d_value: got %h, expected %h", d, op, m_rf[d], exp_rf[d]); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d = $urandom;
        send(1, 1, 0, d, 0);
        @(negedge clk);
        n_checks++; if (o_rf_fun_sel !== 3'b100) $display("FAIL abort_k0_fun: got %b, expected 100", o_rf_fun_sel); else n_pass++;
        @(negedge clk);
        n_checks++; if ({o_rf_fun_sel, o_rf_reg_sel} !== {3'b110, 4'b0100}) $display("FAIL abort_k1: fun %b reg %b, expected 110 0100", o_rf_fun_sel, o_rf_reg_sel); else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if ({o_rf_reg_sel, o_rf_scr_sel} !== 8'h00) $display("FAIL abort_masks: got %b_%b, expected 0000_0000", o_rf_reg_sel, o_rf_scr_sel); else n_pass++;
        n_checks++; if ({o_rf_fun_sel, o_busy, o_cmd_ready, o_done} !== {3'b010, 3'b000}) $display("FAIL abort_ctrl: fun %b busy %b ready %b done %b", o_rf_fun_sel, o_busy, o_cmd_ready, o_done); else n_pass++;
        n_checks++; if ({o_rf_i, o_rf_out_a_sel} !== {32'd0, 3'd0}) $display("FAIL abort_data: rfi %h sel %0d, expected 0 0", o_rf_i, o_rf_out_a_sel); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (o_cmd_ready !== 1'b1) $display("FAIL abort_release_ready: got %b, expected 1", o_cmd_ready); else n_pass++;
        exp_rf[1] = {24'd0, d[31:24]};
        n_checks++; if (m_rf[1] !== exp_rf[1]) $display("FAIL abort_r2_partial: got %h, expected %h", m_rf[1], exp_rf[1]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_move();
        test_inc16();
        test_back_to_back();
        test_all_dst();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
